// File: rtl/dcache_resp_unit.sv
// Data-side responder: accepts one load/store from MEM, runs it on an SRAM-style bus,
// and holds the right-aligned result (or an error) for writeback until it is consumed.
module dcache_resp_unit #(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic [63:0]       mrdata,
  output logic              cache_valid,
  output logic              cache_err,
  input  logic              resp_ready,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata
);

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_reg, state_next;
  logic              wen_reg, wen_next;
  logic [1:0]        size_reg, size_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [63:0]       wdata_reg, wdata_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic [63:0]       mrdata_reg, mrdata_next;
  logic              err_reg, err_next;

  logic [7:0]        cnt_inc;
  logic [2:0]        off;
  logic [5:0]        shamt;
  logic [3:0]        lane_lo, lane_hi;

  // Size encoding follows MemOP: 0 = 8B, 1 = 4B, 2 = 2B, 3 = 1B.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
    case (size)
      2'd0:    return a != 3'd0;
      2'd1:    return a[1:0] != 2'd0;
      2'd2:    return a[0];
      default: return 1'b0;
    endcase
  endfunction

  assign off     = addr_reg[2:0];
  assign shamt   = {off, 3'b000};
  assign cnt_inc = cnt_reg + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      wen_reg    <= 1'b0;
      size_reg   <= 2'd0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      cnt_reg    <= '0;
      mrdata_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wen_reg    <= wen_next;
      size_reg   <= size_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      cnt_reg    <= cnt_next;
      mrdata_reg <= mrdata_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    wen_next    = wen_reg;
    size_next   = size_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    cnt_next    = cnt_reg;
    mrdata_next = mrdata_reg;
    err_next    = err_reg;

    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          wen_next    = req_wen;
          size_next   = req_size;
          addr_next   = req_addr;
          wdata_next  = req_wdata;
          cnt_next    = '0;
          mrdata_next = '0;
          err_next    = 1'b0;
          // Misaligned accesses never touch the bus.
          if (misaligned(req_size, req_addr[2:0])) begin
            err_next   = 1'b1;
            state_next = S_RESP;
          end else begin
            state_next = S_REQ;
          end
        end
      end

      S_REQ: begin
        if (mem_gnt) begin
          cnt_next   = '0;
          state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_next = cnt_inc;
        // Data arriving on the final allowed cycle still wins over the timeout.
        if (mem_rvalid) begin
          mrdata_next = wen_reg ? 64'd0 : (mem_rdata >> shamt);
          err_next    = 1'b0;
          state_next  = S_RESP;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          mrdata_next = '0;
          err_next    = 1'b1;
          state_next  = S_RESP;
        end
      end

      S_RESP: begin
        if (resp_ready) begin
          state_next = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign req_ready   = (state_reg == S_IDLE);
  assign mem_req     = (state_reg == S_REQ);
  assign cache_valid = (state_reg == S_RESP);
  assign cache_err   = err_reg;
  assign mrdata      = mrdata_reg;

  assign mem_wen   = wen_reg;
  assign mem_addr  = {addr_reg[ADDR_W-1:3], 3'b000};
  assign mem_wdata = wdata_reg << shamt;

  // Byte lane gi is written when it falls in [off, off + bytes(size)); lanes past 7 drop off.
  assign lane_lo = {1'b0, off};
  assign lane_hi = lane_lo + (4'd8 >> size_reg);

  for (genvar gi = 0; gi < 8; gi++) begin : g_strb
    localparam logic [3:0] LANE = 4'(gi);
    assign mem_wstrb[gi] = wen_reg && (LANE >= lane_lo) && (LANE < lane_hi);
  end

endmodule
